// File: rtl/read_data_sink_monitor_if.sv
// Read-data stream bundle between the shell (master) and the sink monitor (slave).
interface read_data_sink_monitor_if #(
    parameter int unsigned DATA_BITS = 512
);
    localparam int unsigned BEAT_BYTES = DATA_BITS / 8;

    logic [DATA_BITS-1:0]  tdata;
    logic [BEAT_BYTES-1:0] tkeep;
    logic                  tlast;
    logic                  tvalid;
    logic                  tready;

    modport master (
        output tdata,
        output tkeep,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tlast,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/read_data_sink_monitor.sv
// Read-data sink: accepts every beat, checks tlast framing against the
// configured request set, accumulates byte count / XOR checksum and run time.
module read_data_sink_monitor #(
    parameter int unsigned DATA_BITS      = 512,
    parameter int unsigned TIMEOUT_CYCLES = 16777216
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      ap_start,
    input  logic [63:0]               num_requests,
    input  logic [63:0]               req_size,
    read_data_sink_monitor_if.slave   s_axis,
    output logic                      ap_done,
    output logic                      timeout,
    output logic                      tlast_err,
    output logic                      stray_beat,
    output logic [63:0]               beat_count,
    output logic [63:0]               byte_count,
    output logic [63:0]               data_xor,
    output logic [63:0]               cycle_count
);
    localparam int unsigned BEAT_BYTES = DATA_BITS / 8;
    localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam int unsigned LANES      = DATA_BITS / 64;
    localparam int unsigned KEEP_CW    = $clog2(BEAT_BYTES + 1);
    localparam int unsigned IDLE_W     = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN,
        ST_DONE
    } state_e;

    state_e              state_q, state_d;
    logic                ap_start_q, ap_start_d;
    logic                tready_q, tready_d;
    logic                ap_done_q, ap_done_d;
    logic                timeout_q, timeout_d;
    logic                tlast_err_q, tlast_err_d;
    logic                stray_q, stray_d;
    logic [63:0]         beat_count_q, beat_count_d;
    logic [63:0]         byte_count_q, byte_count_d;
    logic [63:0]         data_xor_q, data_xor_d;
    logic [63:0]         cycle_count_q, cycle_count_d;
    logic [63:0]         req_cnt_q, req_cnt_d;
    logic [63:0]         bpr_q, bpr_d;
    logic [63:0]         expected_q, expected_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;

    logic                beat_fire;
    logic                start_pulse;
    logic                count_beat;
    logic                exp_last;
    logic [KEEP_CW-1:0]  keep_pop;
    logic [63:0]         lane_xor;
    logic [64:0]         bpr_sum;
    logic [63:0]         bpr_calc;

    assign beat_fire   = s_axis.tvalid & tready_q;
    assign start_pulse = ap_start & ~ap_start_q;
    assign count_beat  = beat_fire & ((state_q == ST_ARM) | (state_q == ST_RUN));
    assign exp_last    = (req_cnt_q == bpr_q - 64'd1);
    assign bpr_sum     = {1'b0, req_size} + 65'(BEAT_BYTES - 1);
    assign bpr_calc    = 64'(bpr_sum >> BEAT_SHIFT);

    // Population count of the byte enables of the current beat.
    always_comb begin
        keep_pop = '0;
        for (int i = 0; i < BEAT_BYTES; i++) begin
            keep_pop = keep_pop + KEEP_CW'(s_axis.tkeep[i]);
        end
    end

    // Fold every 64-bit lane of the beat into one word, ignoring tkeep.
    always_comb begin
        lane_xor = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_xor = lane_xor ^ s_axis.tdata[l*64 +: 64];
        end
    end

    // Next-state, accumulator and sticky-flag logic.
    always_comb begin
        state_d       = state_q;
        ap_start_d    = ap_start;
        tready_d      = 1'b1;
        ap_done_d     = ap_done_q;
        timeout_d     = timeout_q;
        tlast_err_d   = tlast_err_q;
        stray_d       = stray_q;
        beat_count_d  = beat_count_q;
        byte_count_d  = byte_count_q;
        data_xor_d    = data_xor_q;
        cycle_count_d = cycle_count_q;
        req_cnt_d     = req_cnt_q;
        bpr_d         = bpr_q;
        expected_d    = expected_q;
        idle_d        = idle_q;

        if (count_beat) begin
            beat_count_d = beat_count_q + 64'd1;
            byte_count_d = byte_count_q + 64'(keep_pop);
            data_xor_d   = data_xor_q ^ lane_xor;
            req_cnt_d    = exp_last ? 64'd0 : req_cnt_q + 64'd1;
            if (s_axis.tlast != exp_last) begin
                tlast_err_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_pulse) begin
                    state_d       = ST_ARM;
                    ap_done_d     = 1'b0;
                    timeout_d     = 1'b0;
                    tlast_err_d   = 1'b0;
                    stray_d       = 1'b0;
                    beat_count_d  = '0;
                    byte_count_d  = '0;
                    data_xor_d    = '0;
                    cycle_count_d = '0;
                    req_cnt_d     = '0;
                    bpr_d         = bpr_calc;
                end else if (beat_fire) begin
                    stray_d = 1'b1;
                end
            end
            ST_ARM: begin
                state_d       = ST_RUN;
                expected_d    = num_requests * bpr_q;
                cycle_count_d = cycle_count_q + 64'd1;
                idle_d        = '0;
            end
            ST_RUN: begin
                cycle_count_d = cycle_count_q + 64'd1;
                idle_d        = beat_fire ? '0 : idle_q + IDLE_W'(1);
                if ((expected_q == 64'd0) || (beat_count_d == expected_q)) begin
                    state_d   = ST_DONE;
                    ap_done_d = 1'b1;
                end else if (!beat_fire && (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1))) begin
                    state_d   = ST_DONE;
                    ap_done_d = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; ap_start_q resets high so a level held across reset is not an edge.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q       <= ST_IDLE;
            ap_start_q    <= 1'b1;
            tready_q      <= 1'b0;
            ap_done_q     <= 1'b0;
            timeout_q     <= 1'b0;
            tlast_err_q   <= 1'b0;
            stray_q       <= 1'b0;
            beat_count_q  <= '0;
            byte_count_q  <= '0;
            data_xor_q    <= '0;
            cycle_count_q <= '0;
            req_cnt_q     <= '0;
            bpr_q         <= '0;
            expected_q    <= '0;
            idle_q        <= '0;
        end else begin
            state_q       <= state_d;
            ap_start_q    <= ap_start_d;
            tready_q      <= tready_d;
            ap_done_q     <= ap_done_d;
            timeout_q     <= timeout_d;
            tlast_err_q   <= tlast_err_d;
            stray_q       <= stray_d;
            beat_count_q  <= beat_count_d;
            byte_count_q  <= byte_count_d;
            data_xor_q    <= data_xor_d;
            cycle_count_q <= cycle_count_d;
            req_cnt_q     <= req_cnt_d;
            bpr_q         <= bpr_d;
            expected_q    <= expected_d;
            idle_q        <= idle_d;
        end
    end

    assign s_axis.tready = tready_q;
    assign ap_done       = ap_done_q;
    assign timeout       = timeout_q;
    assign tlast_err     = tlast_err_q;
    assign stray_beat    = stray_q;
    assign beat_count    = beat_count_q;
    assign byte_count    = byte_count_q;
    assign data_xor      = data_xor_q;
    assign cycle_count   = cycle_count_q;
endmodule

// File: tb/tb_read_data_sink_monitor.sv
// Bench for read_data_sink_monitor: table vectors, random runs against a
// behavioural model, and hand sequences for empty run, timeout and reset.
module tb_read_data_sink_monitor;
    localparam int unsigned DB = 512;
    localparam int unsigned BB = DB / 8;
    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        areset;
    logic        ap_start;
    logic [63:0] num_requests;
    logic [63:0] req_size;
    logic        ap_done, timeout, tlast_err, stray_beat;
    logic [63:0] beat_count, byte_count, data_xor, cycle_count;

    int total = 0;
    int bad   = 0;

    read_data_sink_monitor_if #(.DATA_BITS(DB)) s_axis_if ();

    read_data_sink_monitor #(.DATA_BITS(DB), .TIMEOUT_CYCLES(TO)) dut (
        .aclk         (clk),
        .areset       (areset),
        .ap_start     (ap_start),
        .num_requests (num_requests),
        .req_size     (req_size),
        .s_axis       (s_axis_if.slave),
        .ap_done      (ap_done),
        .timeout      (timeout),
        .tlast_err    (tlast_err),
        .stray_beat   (stray_beat),
        .beat_count   (beat_count),
        .byte_count   (byte_count),
        .data_xor     (data_xor),
        .cycle_count  (cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] nreq;
        logic [63:0] rsize;
        int          nbeats;
        logic [15:0] last_mask;
        logic [15:0] part_mask;
        int          pbytes;
        logic [63:0] exp_beats;
        logic [63:0] exp_bytes;
        logic        exp_err;
    } vec_t;

    logic [DB-1:0] q_data[$];
    logic [BB-1:0] q_keep[$];
    logic          q_last[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DB-1:0] rand_data();
        logic [DB-1:0] d;
        for (int k = 0; k < DB / 32; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [63:0] fold(input logic [DB-1:0] v);
        logic [63:0] r = '0;
        for (int l = 0; l < DB / 64; l++) r = r ^ v[l*64 +: 64];
        return r;
    endfunction

    task automatic send_beat(input logic [DB-1:0] d, input logic [BB-1:0] k, input logic l);
        s_axis_if.tdata  = d;
        s_axis_if.tkeep  = k;
        s_axis_if.tlast  = l;
        s_axis_if.tvalid = 1'b1;
        tick();
        s_axis_if.tvalid = 1'b0;
    endtask

    task automatic start_run(input logic [63:0] nreq, input logic [63:0] rsize);
        num_requests = nreq;
        req_size     = rsize;
        ap_start     = 1'b1;
        tick();
        ap_start     = 1'b0;
    endtask

    // Start a run, play the queued beats with random gaps, compare against the model.
    task automatic run_queued(input string tag, input logic [63:0] nreq, input logic [63:0] rsize,
                              input int gapmax);
        int            cyc;
        logic [DB-1:0] acc;
        logic [63:0]   bytes;
        logic          err;
        longint unsigned bpr;
        bpr   = (rsize + 63) / 64;
        acc   = '0;
        bytes = '0;
        err   = 1'b0;
        cyc   = 0;
        start_run(nreq, rsize);
        check({tag, "_done_clr"}, 64'(ap_done), 64'd0);
        for (int i = 0; i < q_data.size(); i++) begin
            int gaps = $urandom_range(gapmax, 0);
            repeat (gaps) begin
                tick();
                cyc++;
            end
            send_beat(q_data[i], q_keep[i], q_last[i]);
            cyc++;
            acc   = acc ^ q_data[i];
            bytes = bytes + 64'($countones(q_keep[i]));
            if (q_last[i] != (((i + 1) % bpr) == 0)) err = 1'b1;
        end
        check({tag, "_done"},     64'(ap_done),    64'd1);
        check({tag, "_beats"},    beat_count,      64'(q_data.size()));
        check({tag, "_bytes"},    byte_count,      bytes);
        check({tag, "_xor"},      data_xor,        fold(acc));
        check({tag, "_tlasterr"}, 64'(tlast_err),  64'(err));
        check({tag, "_stray"},    64'(stray_beat), 64'd0);
        check({tag, "_timeout"},  64'(timeout),    64'd0);
        check({tag, "_cycles"},   cycle_count,     64'(cyc));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vecs[5];
        logic [BB-1:0] full_keep;
        logic [BB-1:0] pkeep;

        full_keep = '1;
        vecs[0] = '{64'd4, 64'd128, 8, 16'b1010_1010, 16'b0,       0, 64'd8, 64'd512, 1'b0};
        vecs[1] = '{64'd3, 64'd100, 6, 16'b10_1010,   16'b10_1010, 36, 64'd6, 64'd300, 1'b0};
        vecs[2] = '{64'd2, 64'd128, 4, 16'b1001,      16'b0,       0, 64'd4, 64'd256, 1'b1};
        vecs[3] = '{64'd3, 64'd1,   3, 16'b111,       16'b111,     1, 64'd3, 64'd3,   1'b0};
        vecs[4] = '{64'd2, 64'd192, 6, 16'b10_0100,   16'b10_0100, 5, 64'd6, 64'd266, 1'b0};

        areset           = 1'b1;
        ap_start         = 1'b0;
        num_requests     = '0;
        req_size         = '0;
        s_axis_if.tdata  = '0;
        s_axis_if.tkeep  = '0;
        s_axis_if.tlast  = 1'b0;
        s_axis_if.tvalid = 1'b0;
        repeat (3) tick();
        check("rst_tready", 64'(s_axis_if.tready), 64'd0);
        check("rst_done",   64'(ap_done),          64'd0);
        check("rst_beats",  beat_count,            64'd0);
        check("rst_xor",    data_xor,              64'd0);
        areset = 1'b0;
        tick();
        check("tready_up", 64'(s_axis_if.tready), 64'd1);
        tick();

        // Table vectors.
        for (int v = 0; v < 5; v++) begin
            q_data.delete();
            q_keep.delete();
            q_last.delete();
            pkeep = (full_keep >> (BB - vecs[v].pbytes));
            for (int b = 0; b < vecs[v].nbeats; b++) begin
                q_data.push_back(rand_data());
                q_keep.push_back(vecs[v].part_mask[b] ? pkeep : full_keep);
                q_last.push_back(vecs[v].last_mask[b]);
            end
            run_queued($sformatf("vec%0d", v), vecs[v].nreq, vecs[v].rsize, 4);
            check($sformatf("vec%0d_tbl_beats", v), beat_count,       vecs[v].exp_beats);
            check($sformatf("vec%0d_tbl_bytes", v), byte_count,       vecs[v].exp_bytes);
            check($sformatf("vec%0d_tbl_err", v),   64'(tlast_err),   64'(vecs[v].exp_err));
            tick();
        end

        // Beat while DONE: stray flagged, counts frozen.
        send_beat(rand_data(), full_keep, 1'b1);
        check("done_stray",      64'(stray_beat), 64'd1);
        check("done_frozen_bc",  beat_count,      vecs[4].exp_beats);
        check("done_frozen_byt", byte_count,      vecs[4].exp_bytes);
        check("done_held",       64'(ap_done),    64'd1);
        tick();

        // Randomised runs against the model.
        for (int r = 0; r < 6; r++) begin
            logic [63:0]     nreq;
            logic [63:0]     rsize;
            longint unsigned bpr;
            nreq  = 64'($urandom_range(4, 1));
            rsize = 64'($urandom_range(300, 1));
            bpr   = (rsize + 63) / 64;
            q_data.delete();
            q_keep.delete();
            q_last.delete();
            for (longint unsigned b = 0; b < nreq * bpr; b++) begin
                logic l;
                l = (((b + 1) % bpr) == 0);
                if ($urandom_range(7, 0) == 0) l = ~l;
                q_data.push_back(rand_data());
                q_keep.push_back(($urandom_range(1, 0) == 1) ? full_keep : {$urandom, $urandom});
                q_last.push_back(l);
            end
            run_queued($sformatf("rnd%0d", r), nreq, rsize, 4);
            tick();
        end

        // Empty run: done two cycles after the start edge.
        start_run(64'd0, 64'd128);
        check("zero_done_clr",  64'(ap_done),    64'd0);
        check("zero_stray_clr", 64'(stray_beat), 64'd0);
        tick();
        check("zero_done_arm",  64'(ap_done),    64'd0);
        tick();
        check("zero_done",      64'(ap_done),    64'd1);
        check("zero_beats",     beat_count,      64'd0);
        check("zero_cycles",    cycle_count,     64'd2);
        check("zero_err",       64'(tlast_err),  64'd0);
        check("zero_timeout",   64'(timeout),    64'd0);
        tick();

        // Timeout: one beat then silence.
        start_run(64'd2, 64'd64);
        send_beat(rand_data(), full_keep, 1'b1);
        repeat (TO - 1) tick();
        check("to_early",      64'(timeout), 64'd0);
        check("to_early_done", 64'(ap_done), 64'd0);
        tick();
        check("to_flag",  64'(timeout),   64'd1);
        check("to_done",  64'(ap_done),   64'd1);
        check("to_beats", beat_count,     64'd1);
        check("to_bytes", byte_count,     64'd64);
        tick();

        // Reset mid-run, with ap_start held high through reset.
        start_run(64'd4, 64'd128);
        send_beat(rand_data(), full_keep, 1'b0);
        send_beat(rand_data(), full_keep, 1'b1);
        send_beat(rand_data(), full_keep, 1'b0);
        check("pre_rst_beats", beat_count, 64'd3);
        ap_start = 1'b1;
        areset   = 1'b1;
        #1;
        check("mid_rst_beats",  beat_count,            64'd0);
        check("mid_rst_cycles", cycle_count,           64'd0);
        check("mid_rst_bytes",  byte_count,            64'd0);
        check("mid_rst_tready", 64'(s_axis_if.tready), 64'd0);
        tick();
        tick();
        areset = 1'b0;
        tick();
        check("post_rst_tready", 64'(s_axis_if.tready), 64'd1);
        send_beat(rand_data(), full_keep, 1'b1);
        check("held_start_stray", 64'(stray_beat), 64'd1);
        check("held_start_beats", beat_count,      64'd0);
        tick();
        send_beat(rand_data(), full_keep, 1'b1);
        check("held_start_beats2", beat_count,   64'd0);
        check("held_start_done",   64'(ap_done), 64'd0);
        ap_start = 1'b0;
        tick();
        q_data.delete();
        q_keep.delete();
        q_last.delete();
        for (int b = 0; b < 8; b++) begin
            q_data.push_back(rand_data());
            q_keep.push_back(full_keep);
            q_last.push_back((b % 2) == 1);
        end
        run_queued("post_rst_run", 64'd4, 64'd128, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
